dac_sample_driver: RTL and testbench

//  Consumer side of the Pll_CLK divider: drives the DAC with samples from the DDS core.

---
 rtl/dac_sample_driver.sv | 110 +++++++++++
 tb/tb_dac_sample_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_driver.sv
// dac_sample_driver: FIFO-buffered DDS sample path driving a DAC with a divided Dac_CLK.
// Define DAC_OFFSET_BIN_EN to emit offset-binary codes instead of two's complement.
module dac_sample_driver #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic                          Pll_CLK,
    input  logic                          Fg_RESET,
    input  logic                          Dac_Enable,
    input  logic [DIV_W-1:0]              Dac_Div,
    input  logic [DATA_W-1:0]             Smp_Data,
    input  logic                          Smp_Valid,
    output logic                          Smp_Ready,
    output logic                          Dac_CLK,
    output logic [DATA_W-1:0]             Dac_Data,
    output logic                          Dac_Underrun,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef DAC_OFFSET_BIN_EN
    localparam logic [DATA_W-1:0] ZERO_CODE = {1'b1, {(DATA_W-1){1'b0}}};
    function automatic logic [DATA_W-1:0] to_code(input logic [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction
`else
    localparam logic [DATA_W-1:0] ZERO_CODE = '0;
    function automatic logic [DATA_W-1:0] to_code(input logic [DATA_W-1:0] s);
        return s;
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t state, state_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] last_smp;
    logic [DIV_W-1:0] div_q, cnt, cnt_d;
    logic full, empty, push, pop, slot, phase_done;

    assign full       = Fifo_Level == (AW+1)'(FIFO_DEPTH);
    assign empty      = Fifo_Level == '0;
    assign Smp_Ready  = !full && !Fg_RESET;
    assign push       = Smp_Valid && Smp_Ready;
    assign pop        = slot && !empty;
    assign phase_done = cnt == div_q;

    // A slot is the LOW entry: the only cycle where Dac_Data and div_q may change
    always_comb begin
        state_d = state;
        cnt_d   = cnt + DIV_W'(1);
        slot    = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                slot  = Dac_Enable && !empty;
            end
            LOW: if (phase_done) begin
                state_d = HIGH;
                cnt_d   = DIV_W'(1);
            end
            HIGH: if (phase_done) begin
                state_d = IDLE;
                cnt_d   = '0;
                slot    = Dac_Enable;
            end
            default: state_d = IDLE;
        endcase
        if (slot) begin
            state_d = LOW;
            cnt_d   = DIV_W'(1);
        end
    end

    always_ff @(posedge Pll_CLK or posedge Fg_RESET) begin
        if (Fg_RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            div_q        <= DIV_W'(1);
            Dac_CLK      <= 1'b0;
            Dac_Data     <= ZERO_CODE;
            Dac_Underrun <= 1'b0;
            last_smp     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            Fifo_Level   <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            Dac_CLK      <= state_d == HIGH;
            Dac_Underrun <= slot && empty;
            if (slot) begin
                div_q    <= (Dac_Div == '0) ? DIV_W'(1) : Dac_Div;
                Dac_Data <= to_code(empty ? last_smp : mem[rd_ptr]);
            end
            if (pop) begin
                last_smp <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            Fifo_Level <= Fifo_Level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: pointers and level define what is valid
    always_ff @(posedge Pll_CLK)
        if (push)
            mem[wr_ptr] <= Smp_Data;
endmodule

// File: tb/tb_dac_sample_driver.sv
// tb_dac_sample_driver: table vectors plus hand sequences, with a scoreboard
// that predicts the code presented at each rising Dac_CLK from accepted samples.
module tb_dac_sample_driver;
`ifdef DAC_OFFSET_BIN_EN
    localparam bit OFS = 1'b1;
`else
    localparam bit OFS = 1'b0;
`endif
    localparam logic [9:0] ZERO = OFS ? 10'h200 : 10'h000;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, svalid = 1'b0;
    logic [7:0] div = 8'd2;
    logic [9:0] sdata = '0;
    logic sready, dclk, und;
    logic [9:0] ddata;
    logic [2:0] level;

    dac_sample_driver dut (
        .Pll_CLK(clk), .Fg_RESET(rst), .Dac_Enable(en), .Dac_Div(div),
        .Smp_Data(sdata), .Smp_Valid(svalid), .Smp_Ready(sready),
        .Dac_CLK(dclk), .Dac_Data(ddata), .Dac_Underrun(und), .Fifo_Level(level)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, und_cnt = 0, n;
    bit mon_en = 1'b0, und_seen = 1'b0, prev_clk = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] last_raw = '0, e, d1, d2;

    typedef struct {
        logic [7:0] div;
        logic [9:0] smp;
        int         half;
        logic [9:0] code;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [9:0] conv(input logic [9:0] s);
        return OFS ? {~s[9], s[8:0]} : s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for a Dac_CLK transition to lvl; n = Pll_CLK edges taken, d1/d2 = data 1 and 2 edges before
    task automatic wait_edge(input logic lvl, output int cnt);
        logic p;
        cnt = 0;
        do begin
            d2 = d1;
            d1 = ddata;
            p = dclk;
            tick();
            cnt++;
        end while (!(dclk === lvl && p !== lvl) && cnt < 200);
        if (dclk !== lvl) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_dac_clk: got %0b expected %0b after %0d cycles", dclk, lvl, cnt);
        end
    endtask

    task automatic push1(input logic [9:0] v);
        sdata = v;
        svalid = 1'b1;
        tick();
        svalid = 1'b0;
    endtask

    // Scoreboard: record accepted samples, check the code at each rising Dac_CLK
    always @(negedge clk) begin
        if (rst) begin
            prev_clk = 1'b0;
            und_seen = 1'b0;
        end else if (mon_en) begin
            if (und) begin
                und_seen = 1'b1;
                und_cnt++;
            end
            if (dclk && !prev_clk) begin
                if (und_seen)
                    chk("sb_underrun_repeat", ddata, conv(last_raw));
                else if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_no_sample: got %0h expected none", ddata);
                end else begin
                    e = exp_q.pop_front();
                    last_raw = e;
                    chk("sb_data", ddata, conv(e));
                end
                und_seen = 1'b0;
            end
            prev_clk = dclk;
            if (svalid && sready)
                exp_q.push_back(sdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'd0, 10'h001, 1, OFS ? 10'h201 : 10'h001};
        tbl[1] = '{8'd1, 10'h2AB, 1, OFS ? 10'h0AB : 10'h2AB};
        tbl[2] = '{8'd4, 10'h1FF, 4, OFS ? 10'h3FF : 10'h1FF};
        tbl[3] = '{8'd7, 10'h200, 7, OFS ? 10'h000 : 10'h200};
        tbl[4] = '{8'd2, 10'h000, 2, OFS ? 10'h200 : 10'h000};
        tbl[5] = '{8'd3, 10'h155, 3, OFS ? 10'h355 : 10'h155};

        // 1: reset values
        repeat (3) tick();
        chk("rst_dac_clk", dclk, 0);
        chk("rst_dac_data", ddata, ZERO);
        chk("rst_underrun", und, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", sready, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", sready, 1);
        mon_en = 1'b1;

        // 2: back-to-back samples at div 2
        div = 8'd2;
        en = 1'b1;
        push1(10'h005);
        push1(10'h3FF);
        push1(10'h200);
        wait_edge(1'b1, n);
        chk("t2_first_data", ddata, conv(10'h005));
        for (int i = 0; i < 2; i++) begin
            wait_edge(1'b1, n);
            chk("t2_period", n, 4);
            chk("t2_setup_d1", d1, ddata);
            chk("t2_setup_d2", d2, ddata);
            chk("t2_data", ddata, conv(i == 0 ? 10'h3FF : 10'h200));
        end
        en = 1'b0;
        repeat (4) tick();
        chk("t2_idle_clk", dclk, 0);
        chk("t2_hold_data", ddata, conv(10'h200));
        chk("t2_no_underrun", und_cnt, 0);

        // Table: one slot per record, low and high phase length checked
        foreach (tbl[i]) begin
            div = tbl[i].div;
            push1(tbl[i].smp);
            en = 1'b1;
            tick();
            chk("tbl_slot_data", ddata, tbl[i].code);
            wait_edge(1'b1, n);
            chk("tbl_low_len", n, tbl[i].half);
            en = 1'b0;
            wait_edge(1'b0, n);
            chk("tbl_high_len", n, tbl[i].half);
            repeat (2) tick();
        end

        // 3: fill while disabled, ready returns after the first pop
        div = 8'd2;
        svalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sdata = 10'h010 + 10'(i);
            tick();
        end
        chk("t3_full_level", level, 4);
        chk("t3_full_ready", sready, 0);
        sdata = 10'h0AA;
        en = 1'b1;
        tick();
        chk("t3_ready_after_pop", sready, 1);
        chk("t3_level_after_pop", level, 3);
        tick();
        svalid = 1'b0;
        chk("t3_refill_level", level, 4);
        for (int t = 0; t < 100 && level != 0; t++) tick();
        chk("t3_drained", level, 0);
        wait_edge(1'b1, n);
        en = 1'b0;
        repeat (4) tick();
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4: single sample then underrun at div 1
        div = 8'd1;
        push1(10'h123);
        en = 1'b1;
        tick();
        chk("t4_slot_data", ddata, conv(10'h123));
        wait_edge(1'b1, n);
        tick();
        chk("t4_underrun_pulse", und, 1);
        chk("t4_underrun_data", ddata, conv(10'h123));
        tick();
        chk("t4_underrun_one_cycle", und, 0);
        en = 1'b0;
        repeat (3) tick();
        chk("t4_underrun_count", und_cnt, 1);

        // 5: div and enable change mid-LOW
        div = 8'd3;
        push1(10'h0C3);
        push1(10'h0C4);
        en = 1'b1;
        tick();
        chk("t5_slot_data", ddata, conv(10'h0C3));
        tick();
        div = 8'd0;
        en = 1'b0;
        wait_edge(1'b1, n);
        chk("t5_low_remaining", n, 2);
        wait_edge(1'b0, n);
        chk("t5_high_len", n, 3);
        repeat (3) tick();
        chk("t5_idle_clk", dclk, 0);
        chk("t5_level", level, 1);
        en = 1'b1;
        wait_edge(1'b1, n);
        chk("t5_new_low", n, 2);
        chk("t5_new_data", ddata, conv(10'h0C4));
        wait_edge(1'b1, n);
        chk("t5_new_period", n, 2);
        en = 1'b0;
        repeat (3) tick();
        chk("t5_underrun_count", und_cnt, 2);

        // Reset in the middle of a HIGH phase discards everything
        div = 8'd4;
        push1(10'h055);
        push1(10'h066);
        en = 1'b1;
        wait_edge(1'b1, n);
        tick();
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_clk", dclk, 0);
        chk("mid_rst_data", ddata, ZERO);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ready", sready, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_clk", dclk, 0);
        chk("post_rst_data", ddata, ZERO);
        chk("post_rst_ready", sready, 1);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
